// File: rtl/fb_write_buffer_pkg.sv
// Shared framebuffer constants, FSM state encoding and fragment record type.
package fb_pkg;
  localparam int unsigned FB_WIDTH  = 640;
  localparam int unsigned FB_HEIGHT = 480;
  localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned FB_ADDR_W = 19;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic                 color;
  } frag_t;
endpackage

// File: rtl/fb_write_buffer_if.sv
// Fragment stream in and framebuffer write port out; the buffer is the slave side.
interface fb_write_buffer_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              frag_valid;
  logic              frag_ready;
  logic [ADDR_W-1:0] FB_addr;
  logic              color_in;
  logic              finish_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wdata;
  logic              mem_ack;

  modport slave (
    input  frag_valid, FB_addr, color_in, finish_in, mem_ack,
    output frag_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output frag_valid, FB_addr, color_in, finish_in, mem_ack,
    input  frag_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_write_buffer_frag_fifo.sv
// First-word-fall-through FIFO; head is valid whenever empty is low.
module frag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign head  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push && !full) begin
        mem_q[wr_q[AW-1:0]] <= wdata;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop && !empty) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/fb_write_buffer.sv
// Buffers line-drawing fragments, clips off-screen addresses and drains them to
// the framebuffer write port; signals done once a finished line is fully written.
module fb_write_buffer #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned FB_PIXELS = 307200,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  fb_write_buffer_if.slave   bus,
  input  logic               clr_cnt,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pixel_count,
  output logic [CNT_W-1:0]   clip_count
);
  import fb_pkg::ST_IDLE;
  import fb_pkg::ST_ACTIVE;
  import fb_pkg::ST_FLUSH;
  import fb_pkg::ST_DONE;

  localparam int unsigned DW = ADDR_W + 1;

  logic             full, empty;
  logic [DW-1:0]    head;
  logic             accept, in_range, push, clip, pop, rise;
  logic [1:0]       state_q, state_d;
  logic             fin_q;
  logic [CNT_W-1:0] pix_q, clip_q;

  // frag_ready depends only on registered occupancy, never on mem_ack.
  assign bus.frag_ready = !full;
  assign accept         = bus.frag_valid && !full;
  assign in_range       = 32'(bus.FB_addr) < FB_PIXELS;
  assign push           = accept && in_range;
  assign clip           = accept && !in_range;
  assign pop            = !empty && bus.mem_ack;
  assign rise           = bus.finish_in && !fin_q;

  assign bus.mem_we                  = !empty;
  assign {bus.mem_addr, bus.mem_wdata} = head;

  frag_fifo #(
    .DEPTH (DEPTH),
    .W     (DW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({bus.FB_addr, bus.color_in}),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // A rise seen together with a line's first accept closes that line at once,
  // otherwise the consumed edge would leave it stuck in ACTIVE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rise) state_d = ST_FLUSH;
                 else if (accept) state_d = ST_ACTIVE;
      ST_ACTIVE: if (rise) state_d = ST_FLUSH;
      ST_FLUSH:  if (empty && !push) state_d = ST_DONE;
      ST_DONE:   if (rise) state_d = ST_FLUSH;
                 else if (accept) state_d = ST_ACTIVE;
                 else state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= bus.finish_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q  <= '0;
      clip_q <= '0;
    end else if (clr_cnt) begin
      pix_q  <= '0;
      clip_q <= '0;
    end else begin
      if (pop)  pix_q  <= pix_q + 1'b1;
      if (clip) clip_q <= clip_q + 1'b1;
    end
  end

  assign busy        = (state_q == ST_ACTIVE) || (state_q == ST_FLUSH);
  assign done        = (state_q == ST_DONE);
  assign pixel_count = pix_q;
  assign clip_count  = clip_q;
endmodule

// File: doc/fb_write_buffer.md
Name: fb_write_buffer

Overview:
- Sits directly downstream of the line-drawing datapath and consumes its fragment stream (FB_addr, color_out, finish).
- Buffers fragments in a small first-word-fall-through FIFO, drops off-screen addresses, and drains pixels to the framebuffer memory write port through a req/ack handshake.
- Back-pressures the fragment generator through frag_ready; the controller gates en_FB_reg with it.
- Reports line completion (done) only after every fragment of the line has been written.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- ADDR_W, 19, framebuffer address width.
- FB_PIXELS, 307200, number of valid pixel addresses (640x480); addresses >= FB_PIXELS are clipped.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- frag_valid  in  1  fragment present on FB_addr/color_in this cycle.
- frag_ready  out  1  buffer can accept a fragment; equals !full.
- FB_addr  in  ADDR_W  fragment pixel address.
- color_in  in  1  fragment colour bit.
- finish_in  in  1  line-end indication from the fragment generator; a level or a pulse, only the rising edge is used.
- mem_we  out  1  write request to framebuffer.
- mem_addr  out  ADDR_W  write address; equals FIFO head.
- mem_wdata  out  1  write data; equals FIFO head colour.
- mem_ack  in  1  memory accepts the write this cycle (transfer = mem_we && mem_ack).
- clr_cnt  in  1  synchronous clear of both statistics counters.
- busy  out  1  high in ACTIVE and FLUSH.
- done  out  1  one-cycle pulse when the line is fully written.
- pixel_count  out  CNT_W  completed memory writes; wraps modulo 2^CNT_W.
- clip_count  out  CNT_W  dropped fragments; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO emptied; state IDLE.
  - frag_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, both counters 0.
- Accept: frag_valid && frag_ready in cycle N.
  - If FB_addr < FB_PIXELS, the fragment is pushed.
  - Otherwise it is discarded and clip_count increments at the edge ending cycle N.
  - A clipped fragment is still consumed and still moves IDLE->ACTIVE.
- Push on full: never occurs. frag_ready = !full, with no combinational path from mem_ack.
  - A pop in the same cycle as full does not enable a push that cycle.
- Push and pop in the same cycle (not full, not empty): occupancy is unchanged; order is preserved.
- Latency: a fragment pushed at edge N into an empty FIFO appears on mem_we/mem_addr/mem_wdata in cycle N+1.
- Memory port:
  - mem_we = !empty.
  - The head is held stable while mem_we && !mem_ack.
  - On mem_ack the entry pops and pixel_count increments.
  - mem_ack while mem_we=0 is ignored.
- Pointers: log2(DEPTH) bits plus one wrap bit.
  - full when the index bits match and the wrap bits differ.
  - empty when all bits match.
- FSM states and transitions:
  - IDLE -> ACTIVE on an accept.
  - IDLE -> FLUSH on a finish_in rise with nothing accepted (zero-length line).
  - ACTIVE -> FLUSH on a finish_in rise (registered edge detect).
    - A fragment accepted in the same cycle as the rise belongs to the line.
  - FLUSH -> DONE when the FIFO is empty and no transfer is pending.
    - Fragments still accepted in FLUSH are drained before leaving FLUSH.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
    - An accept in DONE still moves to ACTIVE next.
- A second finish_in rise while in FLUSH is ignored.
- clr_cnt zeroes both counters and has priority over a same-cycle increment.
- Mid-operation reset discards the FIFO contents without completing the pending write; mem_we drops immediately.

Decomposition:
- Shared package fb_pkg holds:
  - constants FB_WIDTH=640, FB_HEIGHT=480, FB_PIXELS=307200, FB_ADDR_W=19;
  - the state encoding (IDLE, ACTIVE, FLUSH, DONE);
  - the fragment record type {addr[18:0], color}.
- One sub-module, frag_fifo: a parameterised synchronous FWFT FIFO with push, pop, full, empty and head outputs, same clock and reset.
- The FSM, clipping and counters live in fb_write_buffer.

Test Plan:
1. mem_ack held at 1; 5 fragments at addrs 0..4, colour 1, then a finish_in pulse -> 5 writes with mem_addr 0..4 in order, each one cycle after acceptance; pixel_count=5; done pulses once, 1 cycle after the last write.
2. mem_ack held at 0; 10 fragments offered -> frag_ready falls after 8 accepts (DEPTH=8); mem_addr holds at the first address; release mem_ack -> 8 in-order writes, then the remaining 2.
3. Fragments at addr 307199, 307200 and 524287 -> one write (307199); clip_count=2; pixel_count=1.
4. finish_in asserted in the same cycle as the last fragment's accept, with mem_ack toggling 1/0 -> done only after the last write acks; busy high throughout.
5. finish_in with no fragments -> FLUSH, then done at the 2nd edge after the rise; no mem_we.
6. rst pulsed low while the FIFO holds 3 entries -> mem_we=0 asynchronously; counters 0; frag_ready=1; no done pulse afterwards.
